// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch into a DEPTH-entry prefetch queue
// with redirect support, feeding decode through a valid/ready handshake.
`default_nettype none

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            queue_full
);

    localparam int              PW    = $clog2(DEPTH);
    localparam logic [PW:0]     FULL  = (PW+1)'(DEPTH);
    localparam logic [XLEN-1:0] FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];

    logic push;
    logic pop;

    // id_valid already masks redirect, so pop never fires on a redirect edge.
    assign id_valid    = (count != '0) && !redirect_valid;
    assign pop         = id_valid && id_ready;
    assign push        = !redirect_valid && ((count < FULL) || pop);

    assign imem_addr   = fetch_pc;
    assign id_instr    = q_instr[head];
    assign id_pc       = q_pc[head];
    assign id_pc_plus4 = q_pc[head] + FOUR;
    assign queue_full  = (count == FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + FOUR;
                tail     <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= fetch_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0).
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        queue_full;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .queue_full     (queue_full)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hFFFF_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;

        // Held in reset
        #2;
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_full", {31'b0, queue_full}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        step();
        step();
        #3 reset = 1'b1;

        // Streaming from reset: one instruction per cycle starting in cycle 2
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", {31'b0, id_valid}, 32'h1);
            check("stream_pc", id_pc, 32'(i * 4));
            check("stream_instr", id_instr, 32'(i * 4) ^ 32'hFFFF_0000);
        end
        check("stream_plus4", id_pc_plus4, 32'd16);

        // Fill to count=3, then assert reset between edges
        id_ready = 1'b0;
        step();
        step();
        #3 reset = 1'b0;
        #1;
        check("async_valid", {31'b0, id_valid}, 32'h0);
        check("async_addr", imem_addr, 32'h0);
        check("async_full", {31'b0, queue_full}, 32'h0);
        step();
        #3 reset = 1'b1;

        // Backpressure: four pushes fill the queue, then everything holds
        for (int i = 1; i <= 3; i++) begin
            step();
            check("bp_notfull", {31'b0, queue_full}, 32'h0);
            check("bp_head", id_pc, 32'h0);
        end
        step();
        check("bp_full", {31'b0, queue_full}, 32'h1);
        check("bp_addr", imem_addr, 32'd16);
        for (int i = 0; i < 6; i++) step();
        check("bp_hold_full", {31'b0, queue_full}, 32'h1);
        check("bp_hold_addr", imem_addr, 32'd16);
        check("bp_hold_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_pc", id_pc, 32'(i * 4));
            check("drain_full", {31'b0, queue_full}, 32'h1);
        end

        // Redirect while full
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check("redir_mask", {31'b0, id_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("redir_addr", imem_addr, 32'h100);
        check("redir_valid", {31'b0, id_valid}, 32'h0);
        check("redir_full", {31'b0, queue_full}, 32'h0);
        step();
        check("redir_tgt_valid", {31'b0, id_valid}, 32'h1);
        check("redir_tgt_pc", id_pc, 32'h100);
        check("redir_tgt_instr", id_instr, 32'hFFFF_0100);
        step();
        check("redir_next_pc", id_pc, 32'h104);

        // Redirect coinciding with a handshake at count=2, target wraps
        id_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        id_ready       = 1'b1;
        #1;
        check("hs_mask", {31'b0, id_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("hs_empty", {31'b0, id_valid}, 32'h0);
        check("hs_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        step();
        check("wrap_next_pc", id_pc, 32'h0);
        check("wrap_next_instr", id_instr, 32'hFFFF_0000);
        check("wrap_next_plus4", id_pc_plus4, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
